mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's memory port. It serves word reads and writes requested over adr/writedata/readdata.
- Adds a req/ready handshake with a programmable number of wait states. This lets the multicycle controller be exercised against slow memory, not only the zero-latency memory model.
- Sits between the multicycle datapath/controller (the initiator) and a local word-organised RAM array held inside this block.

Parameters:
- DEPTH_LOG2, 6, log2 of the number of 32-bit words in the array (default 64 words).
- WAIT_CYCLES, 2, extra cycles between request acceptance and response (0..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request strobe from the initiator; sampled only in IDLE.
- we  input  1  write enable qualifying req (1 = write, 0 = read).
- adr  input  32  byte address; word index = adr[DEPTH_LOG2+1:2].
- writedata  input  32  write data, captured with the request.
- readdata  output  32  registered read data.
- ready  output  1  response strobe, high for exactly one cycle per request.
- busy  output  1  high while a request is outstanding (BUSY or RESP state).

Behaviour:
- Reset values: state IDLE, ready=0, busy=0, readdata=0, wait counter=0. Reset does not clear the RAM contents.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - ready=0, busy=0.
  - If req=1 at a rising edge: latch adr word index, we and writedata; load counter with WAIT_CYCLES; go to BUSY.
- BUSY:
  - busy=1, ready=0.
  - At each edge: if counter==0, perform the access and go to RESP; otherwise decrement counter.
  - Read access: readdata <= mem[index].
  - Write access: mem[index] <= writedata; readdata unchanged.
- RESP:
  - ready=1, busy=1 for one cycle; next edge returns to IDLE unconditionally.
  - req is ignored in RESP. A new request is accepted no earlier than the first IDLE edge.
- Latency: req sampled at edge N -> ready high in the cycle after edge N+1+WAIT_CYCLES. With WAIT_CYCLES=0, ready rises after edge N+1.
- Minimum request spacing: WAIT_CYCLES+3 cycles.
- Input stability: adr, we and writedata changes after acceptance have no effect; the latched copies are used.
- readdata holds its value until the next completed read. It remains valid after ready drops.
- Address rules (no error reporting without the optional feature):
  - adr[1:0] ignored.
  - Bits above DEPTH_LOG2+1 ignored, so addresses alias modulo 2^DEPTH_LOG2 words.
- Reset asserted in BUSY: the access is aborted, no RAM write is committed, state returns to IDLE.
- Reset asserted in RESP: ready drops immediately (asynchronous). A write already committed stays committed.
- req held high continuously: a new request is accepted every WAIT_CYCLES+3 cycles.

Optional Feature:
- Macro: MEM_RESPONDER_ERR_EN.
- With the macro defined:
  - Extra output err (1 bit, reset 0), valid only when ready=1.
  - err=1 if the latched adr[1:0]!=0, or if any of adr[31:DEPTH_LOG2+2] is non-zero.
  - On error: writes are suppressed, reads leave readdata unchanged, and ready still pulses with normal latency.
- Without the macro: no err port, and the aliasing/ignore rules above apply.

Test Plan:
- Reset then idle: hold reset 3 cycles, release -> ready=0, busy=0, readdata=0x00000000 for 10 cycles with req=0.
- Write/read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to adr 0x0000_0010, req accepted at edge N -> ready high only in the cycle after edge N+3.
  - Then read adr 0x10 -> readdata=0xDEADBEEF when ready=1.
- Zero wait, WAIT_CYCLES=0: read adr 0x0 after writing 0x12345678 -> ready after edge N+1; req held high back-to-back yields ready every 3 cycles.
- Reset mid-operation: write 0xCAFEF00D to adr 0x20, assert reset during BUSY -> ready never pulses; a subsequent read of 0x20 returns the prior contents.
- Aliasing, DEPTH_LOG2=6, macro off: write 0x000000AA to adr 0x104 -> read of adr 0x004 returns 0x000000AA.
- Error path, macro on: write to adr 0x0000_0012 -> ready pulses with err=1; a read of 0x10 is unchanged. Read of adr 0x0000_1000 -> err=1, readdata unchanged.

Source files
------------

// File: rtl/mem_responder_if.sv
// Initiator <-> memory responder handshake: req/we/adr/writedata out, readdata/ready/busy back.
// err exists only when MEM_RESPONDER_ERR_EN is defined.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;
  logic        busy;
`ifdef MEM_RESPONDER_ERR_EN
  logic        err;

  modport master (output req, we, adr, writedata, input readdata, ready, busy, err);
  modport slave  (input req, we, adr, writedata, output readdata, ready, busy, err);
`else
  modport master (output req, we, adr, writedata, input readdata, ready, busy);
  modport slave  (input req, we, adr, writedata, output readdata, ready, busy);
`endif
endinterface

// File: rtl/mem_responder.sv
// Word RAM responder: request sampled in IDLE, ready pulses one cycle WAIT_CYCLES+1 edges after acceptance.
// Requests arriving while busy are ignored; MEM_RESPONDER_ERR_EN adds err for misaligned/out-of-range adr.
module mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [7:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  we_q;
  logic [31:0]           wdat_q;
  logic                  bad_q;
  logic [31:0]           mem [WORDS];
  logic                  addr_bad;
  logic                  access;
  logic                  mem_wr;

`ifdef MEM_RESPONDER_ERR_EN
  assign addr_bad = (bus.adr[1:0] != 2'b00) || (bus.adr[31:DEPTH_LOG2+2] != '0);
`else
  // Without error reporting the low and high address bits simply alias.
  logic unused_adr_bits;
  assign addr_bad        = 1'b0;
  assign unused_adr_bits = ^{bus.adr[1:0], bus.adr[31:DEPTH_LOG2+2]};
`endif

  assign access = (state == BUSY) && (cnt == 8'd0);
  // Reset gating keeps an aborted write from landing if reset and the edge coincide.
  assign mem_wr = access && we_q && !bad_q && !reset;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[idx_q] <= wdat_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      idx_q         <= '0;
      we_q          <= 1'b0;
      wdat_q        <= '0;
      bad_q         <= 1'b0;
      bus.ready     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.readdata  <= '0;
`ifdef MEM_RESPONDER_ERR_EN
      bus.err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            idx_q    <= bus.adr[DEPTH_LOG2+1:2];
            we_q     <= bus.we;
            wdat_q   <= bus.writedata;
            bad_q    <= addr_bad;
            cnt      <= 8'(WAIT_CYCLES);
            bus.busy <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            if (!we_q && !bad_q) begin
              bus.readdata <= mem[idx_q];
            end
`ifdef MEM_RESPONDER_ERR_EN
            bus.err   <= bad_q;
`endif
            bus.ready <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          bus.ready <= 1'b0;
          bus.busy  <= 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
          bus.err   <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder: a word-array reference model predicts readdata,
// err and the ready cycle for each accepted request; a negedge monitor pops and compares.
module tb_mem_responder;

  localparam int DL2   = 6;
  localparam int W     = 2;
  localparam int WORDS = 1 << DL2;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  exp_t        sb[$];
  logic [31:0] ram_m [WORDS];
  logic [31:0] last_rd = 32'h0;

  mem_responder_if bus();

  mem_responder #(
    .DEPTH_LOG2  (DL2),
    .WAIT_CYCLES (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: word array indexed by (adr/4) mod WORDS; a read updates the held readdata.
  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d, input int acc);
    exp_t e;
    logic bad;
    int   idx;
    bad = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
    bad = ((a % 4) != 0) || (a >= 32'(4 * WORDS));
`endif
    idx = int'((a / 4) % WORDS);
    if (!bad) begin
      if (w) ram_m[idx] = d;
      else   last_rd    = ram_m[idx];
    end
    e.rd  = last_rd;
    e.err = bad;
    e.cyc = acc + 1 + W;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ready: ready=1 at cycle %0d, expected no pending request", cyc);
      end else begin
        e = sb.pop_front();
        check("latency", 32'(cyc), 32'(e.cyc));
        check("readdata", bus.readdata, e.rd);
        check("busy_in_resp", 32'(bus.busy), 32'd1);
`ifdef MEM_RESPONDER_ERR_EN
        check("err", 32'(bus.err), 32'(e.err));
`endif
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = !bus.busy && !bus.ready && (sb.size() == 0);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: busy=%0b ready=%0b pending=%0d, expected idle with none pending",
               bus.busy, bus.ready, sb.size());
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    bus.req       = 1'b1;
    bus.we        = w;
    bus.adr       = a;
    bus.writedata = d;
    @(posedge clk);
    #1;
    sb.push_back(model(w, a, d, cyc));
    // Scramble the inputs after acceptance; the latched copies must be used.
    bus.req       = 1'b0;
    bus.we        = 1'($urandom);
    bus.adr       = $urandom;
    bus.writedata = $urandom;
  endtask

  initial begin
    int acc0;
    bit seen;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.adr       = '0;
    bus.writedata = '0;

    // Reset, then idle with req low.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(bus.ready), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_readdata", bus.readdata, 32'h0);
    end

    // Fill the whole array so every later read has a known value.
    for (int i = 0; i < WORDS; i++) issue(1'b1, 32'(i) << 2, $urandom);

    // Directed write/read, aliasing and error-path patterns.
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0000_0010, 32'h0);
    issue(1'b1, 32'h0000_0104, 32'h0000_00AA);
    issue(1'b0, 32'h0000_0004, 32'h0);
    issue(1'b1, 32'h0000_0012, 32'h5555_AAAA);
    issue(1'b0, 32'h0000_0010, 32'h0);
    issue(1'b0, 32'h0000_1000, 32'h0);
    issue(1'b0, 32'h0000_0000, 32'h0);

    // req held high: one acceptance every W+3 cycles.
    wait_idle();
    bus.req = 1'b1;
    bus.we  = 1'b0;
    bus.adr = 32'h0000_0010;
    @(posedge clk);
    #1;
    acc0 = cyc;
    for (int k = 0; k < 4; k++) sb.push_back(model(1'b0, 32'h0000_0010, 32'h0, acc0 + k * (W + 3)));
    repeat (3 * (W + 3)) @(posedge clk);
    #1;
    bus.req = 1'b0;

    // Reset while BUSY: the write is aborted and ready never pulses.
    wait_idle();
    bus.req       = 1'b1;
    bus.we        = 1'b1;
    bus.adr       = 32'h0000_0020;
    bus.writedata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd0);
    check("abort_readdata", bus.readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    last_rd = 32'h0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(bus.ready), 32'd0);
    end
    issue(1'b0, 32'h0000_0020, 32'h0);

    // Reset during RESP: ready drops at once, the committed write survives.
    issue(1'b1, 32'h0000_0030, 32'h0BAD_F00D);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = bus.ready;
    end
    check("resp_ready_seen", 32'(seen), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("resp_reset_ready", 32'(bus.ready), 32'd0);
    check("resp_reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    last_rd = 32'h0;
    issue(1'b0, 32'h0000_0030, 32'h0);

    // Random traffic: mostly in-range aligned, sometimes arbitrary addresses.
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) != 0) a = 32'($urandom_range(0, WORDS - 1)) << 2;
      else                            a = $urandom;
      issue(1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
